config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 137 +++++++++++++
 tb/tb_config_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Serial configuration loader: unpacks host words LSB-first into a
// config_cell chain of chain_len bits, one bit per config_shift cycle.
//
// Ports:
//   config_clk    - single clock
//   config_reset  - async active-low reset
//   start         - begin a load (honoured in IDLE only)
//   word_in       - bitstream word, size bits
//   word_valid    - word_in valid
//   word_ready    - loader accepts word_in this cycle (WAIT_WORD)
//   config_out    - serial bit into the chain head
//   config_shift  - chain captures config_out when 1
//   busy          - load in progress (WAIT_WORD, SHIFT, DONE)
//   done          - one-cycle pulse after the last chain bit
module config_loader #(
    parameter int size      = 32,
    parameter int chain_len = 40
) (
    input  logic            config_clk,
    input  logic            config_reset,
    input  logic            start,
    input  logic [size-1:0] word_in,
    input  logic            word_valid,
    output logic            word_ready,
    output logic            config_out,
    output logic            config_shift,
    output logic            busy,
    output logic            done
);

    localparam int BIT_W  = $clog2(chain_len + 1);
    localparam int WORD_W = $clog2(size + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(chain_len);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(size);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        SHIFT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [size-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] word_cnt_q, word_cnt_d;

    logic [BIT_W-1:0]  bit_cnt_inc;
    logic [WORD_W-1:0] word_cnt_inc;

    always_ff @(posedge config_clk or negedge config_reset) begin
        if (!config_reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        bit_cnt_inc  = bit_cnt_q + 1'b1;
        word_cnt_inc = word_cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WAIT_WORD;
                    bit_cnt_d = '0;
                end
            end
            WAIT_WORD: begin
                // word_ready is 1 here, so valid alone completes the handshake
                if (word_valid) begin
                    shreg_d    = word_in;
                    word_cnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d    = shreg_q >> 1;
                bit_cnt_d  = bit_cnt_inc;
                word_cnt_d = word_cnt_inc;
                // Chain end wins over word end, so a partial final word
                // leaves its upper bits unshifted and bit_cnt never wraps.
                if (bit_cnt_inc == BIT_LAST) begin
                    state_d = DONE;
                end else if (word_cnt_inc == WORD_LAST) begin
                    state_d = WAIT_WORD;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        word_ready   = 1'b0;
        config_out   = 1'b0;
        config_shift = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
            end
            WAIT_WORD: begin
                word_ready = 1'b1;
            end
            SHIFT: begin
                config_out   = shreg_q[0];
                config_shift = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: four instances with different
// chain lengths, a bit scoreboard filled from driven words.
module tb_config_loader;

    localparam int N = 4;
    localparam int CL [N] = '{40, 3, 64, 32};

    logic          config_clk;
    logic          config_reset;
    logic [N-1:0]  start;
    logic [N-1:0]  word_valid;
    logic [31:0]   word_in;
    wire  [N-1:0]  cfg_ready;
    wire  [N-1:0]  cfg_out;
    wire  [N-1:0]  cfg_shift;
    wire  [N-1:0]  cfg_busy;
    wire  [N-1:0]  cfg_done;

    for (genvar g = 0; g < N; g++) begin : g_dut
        config_loader #(
            .size      (32),
            .chain_len (CL[g])
        ) u_dut (
            .config_clk   (config_clk),
            .config_reset (config_reset),
            .start        (start[g]),
            .word_in      (word_in),
            .word_valid   (word_valid[g]),
            .word_ready   (cfg_ready[g]),
            .config_out   (cfg_out[g]),
            .config_shift (cfg_shift[g]),
            .busy         (cfg_busy[g]),
            .done         (cfg_done[g])
        );
    end

    initial config_clk = 1'b0;
    always #5 config_clk = ~config_clk;

    int errors = 0;
    int checks = 0;

    bit          exp_q[$];
    logic [31:0] words[$];

    int r_nshift, r_nready, r_bit_err, r_gap, r_done_gap;
    int r_done_len, r_busy_after, r_stray;

    // Drives one complete load on instance i and gathers statistics;
    // the scoreboard is filled from the words before the load starts.
    task automatic run_load(input int i, input int chain,
                            input int stall, input int start_at);
        int rem, n, wi, stall_left, last_shift, done_cyc;
        bit e, fin;
        exp_q.delete();
        rem = chain;
        for (int w = 0; w < words.size(); w++) begin
            n = rem < 32 ? rem : 32;
            for (int b = 0; b < n; b++) exp_q.push_back(words[w][b]);
            rem -= n;
        end
        r_nshift = 0; r_nready = 0; r_bit_err = 0; r_gap = 0;
        r_done_gap = -1; r_done_len = 0; r_busy_after = 1; r_stray = 0;
        wi = 0; stall_left = 0; last_shift = -1; done_cyc = -1; fin = 0;
        @(negedge config_clk);
        start[i] = 1'b1;
        word_in = words[0];
        word_valid[i] = 1'b1;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            @(negedge config_clk);
            start[i] = 1'b0;
            if (!cfg_busy[i]) r_stray++;
            if (!cfg_shift[i] && cfg_out[i]) r_stray++;
            if (cfg_shift[i]) begin
                if (exp_q.size() == 0) r_bit_err++;
                else begin
                    e = exp_q.pop_front();
                    if (cfg_out[i] !== e) r_bit_err++;
                end
                if (last_shift >= 0 && cyc - last_shift - 1 > r_gap)
                    r_gap = cyc - last_shift - 1;
                r_nshift++;
                last_shift = cyc;
                word_in = (wi < words.size()) ? words[wi] : 32'h0;
                if (r_nshift == start_at) start[i] = 1'b1;
            end
            if (cfg_ready[i]) begin
                r_nready++;
                if (cfg_shift[i]) r_stray++;
                if (stall_left > 0) begin
                    word_valid[i] = 1'b0;
                    stall_left--;
                end else begin
                    word_valid[i] = 1'b1;
                    wi++;
                    stall_left = stall;
                end
            end
            if (cfg_done[i]) begin
                done_cyc = cyc;
                r_done_gap = (last_shift >= 0) ? cyc - last_shift : -1;
                fin = 1;
            end
        end
        word_valid[i] = 1'b0;
        start[i] = 1'b0;
        if (fin) begin
            @(negedge config_clk);
            r_done_len = cfg_done[i] ? 2 : 1;
            r_busy_after = cfg_busy[i];
        end
        r_bit_err += exp_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset;
        config_reset = 1'b0;
        start = '0;
        word_valid = '0;
        word_in = 32'h0;
        repeat (2) @(negedge config_clk);
        checks++;
        if ({cfg_ready, cfg_out, cfg_shift, cfg_busy, cfg_done} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {cfg_ready, cfg_out, cfg_shift, cfg_busy, cfg_done});
        end
        config_reset = 1'b1;
        repeat (3) @(negedge config_clk);
        checks++;
        if ({cfg_ready, cfg_busy} !== 8'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h want 0",
                     {cfg_ready, cfg_busy});
        end
    endtask

    task automatic test_load_40;
        words = '{32'hA5A5A5A5, 32'h000000C3};
        run_load(0, 40, 0, -1);
        checks++;
        if (r_nshift !== 40) begin errors++;
            $display("FAIL l40_shifts: got %0d want 40", r_nshift); end
        checks++;
        if (r_bit_err !== 0) begin errors++;
            $display("FAIL l40_bits: got %0d bad want 0", r_bit_err); end
        checks++;
        if (r_nready !== 2) begin errors++;
            $display("FAIL l40_ready: got %0d want 2", r_nready); end
        checks++;
        if (r_gap !== 1) begin errors++;
            $display("FAIL l40_word_gap: got %0d want 1", r_gap); end
        checks++;
        if (r_done_gap !== 1) begin errors++;
            $display("FAIL l40_done_gap: got %0d want 1", r_done_gap); end
        checks++;
        if (r_done_len !== 1) begin errors++;
            $display("FAIL l40_done_len: got %0d want 1", r_done_len); end
        checks++;
        if (r_busy_after !== 0) begin errors++;
            $display("FAIL l40_busy_after: got %0d want 0", r_busy_after); end
        checks++;
        if (r_stray !== 0) begin errors++;
            $display("FAIL l40_stray: got %0d want 0", r_stray); end
    endtask

    task automatic test_short_chain;
        words = '{32'h00000004};
        run_load(1, 3, 0, -1);
        checks++;
        if (r_nshift !== 3) begin errors++;
            $display("FAIL short_shifts: got %0d want 3", r_nshift); end
        checks++;
        if (r_bit_err !== 0) begin errors++;
            $display("FAIL short_bits: got %0d bad want 0", r_bit_err); end
        checks++;
        if (r_nready !== 1) begin errors++;
            $display("FAIL short_ready: got %0d want 1", r_nready); end
        checks++;
        if (r_done_gap !== 1) begin errors++;
            $display("FAIL short_done_gap: got %0d want 1", r_done_gap); end
    endtask

    task automatic test_stall;
        words = '{32'h12345678, 32'hDEADBEEF};
        run_load(2, 64, 5, -1);
        checks++;
        if (r_nshift !== 64) begin errors++;
            $display("FAIL stall_shifts: got %0d want 64", r_nshift); end
        checks++;
        if (r_bit_err !== 0) begin errors++;
            $display("FAIL stall_bits: got %0d bad want 0", r_bit_err); end
        checks++;
        if (r_nready !== 7) begin errors++;
            $display("FAIL stall_ready: got %0d want 7", r_nready); end
        checks++;
        if (r_gap !== 6) begin errors++;
            $display("FAIL stall_gap: got %0d want 6", r_gap); end
        checks++;
        if (r_stray !== 0) begin errors++;
            $display("FAIL stall_stray: got %0d want 0", r_stray); end
    endtask

    task automatic test_start_in_shift;
        words = '{32'h0F0F3C3C, 32'h000000A6};
        run_load(0, 40, 0, 5);
        checks++;
        if (r_nshift !== 40) begin errors++;
            $display("FAIL sis_shifts: got %0d want 40", r_nshift); end
        checks++;
        if (r_bit_err !== 0) begin errors++;
            $display("FAIL sis_bits: got %0d bad want 0", r_bit_err); end
        checks++;
        if (r_done_gap !== 1) begin errors++;
            $display("FAIL sis_done_gap: got %0d want 1", r_done_gap); end
        checks++;
        if (r_nready !== 2) begin errors++;
            $display("FAIL sis_ready: got %0d want 2", r_nready); end
    endtask

    task automatic test_exact_word;
        words = '{32'h8000_0001};
        run_load(3, 32, 0, -1);
        checks++;
        if (r_nshift !== 32) begin errors++;
            $display("FAIL exact_shifts: got %0d want 32", r_nshift); end
        checks++;
        if (r_nready !== 1) begin errors++;
            $display("FAIL exact_ready: got %0d want 1", r_nready); end
        checks++;
        if (r_done_gap !== 1) begin errors++;
            $display("FAIL exact_done_gap: got %0d want 1", r_done_gap); end
        checks++;
        if (r_bit_err !== 0) begin errors++;
            $display("FAIL exact_bits: got %0d bad want 0", r_bit_err); end
    endtask

    task automatic test_reset_abort;
        int n, bad;
        @(negedge config_clk);
        start[0] = 1'b1;
        word_in = 32'hFFFFFFFF;
        word_valid[0] = 1'b1;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(negedge config_clk);
            start[0] = 1'b0;
            if (cfg_shift[0]) n++;
        end
        checks++;
        if ({cfg_shift[0], cfg_out[0]} !== 2'b11) begin errors++;
            $display("FAIL abort_pre: got %b want 11",
                     {cfg_shift[0], cfg_out[0]}); end
        #2 config_reset = 1'b0;
        #1;
        checks++;
        if ({cfg_ready[0], cfg_out[0], cfg_shift[0], cfg_busy[0],
             cfg_done[0]} !== 5'b0) begin errors++;
            $display("FAIL abort_async: got %b want 00000",
                     {cfg_ready[0], cfg_out[0], cfg_shift[0],
                      cfg_busy[0], cfg_done[0]}); end
        bad = 0;
        repeat (3) begin
            @(negedge config_clk);
            if (cfg_shift[0]) bad++;
        end
        config_reset = 1'b1;
        repeat (5) begin
            @(negedge config_clk);
            if (cfg_shift[0] || cfg_busy[0] || cfg_ready[0]) bad++;
        end
        word_valid[0] = 1'b0;
        checks++;
        if (bad !== 0) begin errors++;
            $display("FAIL abort_no_restart: got %0d want 0", bad); end
        words = '{32'hA5A5A5A5, 32'h000000C3};
        run_load(0, 40, 0, -1);
        checks++;
        if (r_nshift !== 40) begin errors++;
            $display("FAIL reload_shifts: got %0d want 40", r_nshift); end
        checks++;
        if (r_bit_err !== 0) begin errors++;
            $display("FAIL reload_bits: got %0d bad want 0", r_bit_err); end
        checks++;
        if (r_done_gap !== 1) begin errors++;
            $display("FAIL reload_done_gap: got %0d want 1", r_done_gap); end
    endtask

    initial begin
        test_reset();
        test_load_40();
        test_short_chain();
        test_stall();
        test_start_in_shift();
        test_exact_word();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
